uart_rotate_cfg: RTL and testbench

UART_ROTATE_CFG -- requirements
Module: uart_rotate_cfg

---
 rtl/uart_rotate_cfg.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_uart_rotate_cfg.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rotate_cfg.sv
// UART-controlled configuration for the video rotate stage.
// A 5-byte packet (0x55 CMD DHI DLO SUM) sets the angle or the bypass; each packet gets an ACK or NAK byte.
module uart_rotate_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int ANGLE_INIT = 180
) (
   input  logic       I_sys_clk,
   input  logic       I_rst_n,
   input  logic       I_uart_rxd,
   output logic       O_uart_txd,
   output logic [8:0] O_angle,
   output logic       O_bypass,
   output logic       O_cfg_update
);

   localparam int DIV     = CLK_FREQ / BAUD_RATE;
   localparam int HALF    = DIV / 2;
   localparam int TIMEOUT = 40 * DIV;
   localparam int CNT_W   = $clog2(DIV + 1);
   localparam int TO_W    = $clog2(TIMEOUT + 1);

   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);

   localparam logic [7:0] HDR_BYTE = 8'h55;
   localparam logic [7:0] ACK_BYTE = 8'hAA;
   localparam logic [7:0] NAK_BYTE = 8'hEE;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_CMD, P_DHI, P_DLO, P_SUM} p_state_t;
   typedef enum logic {T_IDLE, T_BUSY} tx_state_t;

   logic             rx_meta_q, rx_meta_d;
   logic             rx_sync_q, rx_sync_d;
   logic             rx_prev_q, rx_prev_d;
   rx_state_t        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_ferr_q, rx_ferr_d;

   p_state_t         p_state_q, p_state_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [7:0]       dhi_q, dhi_d;
   logic [7:0]       dlo_q, dlo_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [8:0]       angle_q, angle_d;
   logic             bypass_q, bypass_d;
   logic             cfg_update_q, cfg_update_d;
   logic             reply_req_q, reply_req_d;
   logic [7:0]       reply_byte_q, reply_byte_d;
   logic [7:0]       sum_c;
   logic [15:0]      value_c;

   tx_state_t        tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]       tx_bit_q, tx_bit_d;
   logic [8:0]       tx_shift_q, tx_shift_d;
   logic             txd_q, txd_d;

   // Sync flops reset low so a line already low at release never looks like a falling edge.
   always_comb begin
      rx_meta_d  = I_uart_rxd;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = R_START;
               rx_cnt_d   = '0;
            end
         end
         R_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = R_IDLE;
               end else begin
                  rx_state_d = R_DATA;
                  rx_bit_d   = '0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         R_DATA: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = R_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         R_STOP: begin
            if (rx_cnt_q == DIV_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = R_IDLE;
               rx_valid_d = rx_sync_q;
               rx_ferr_d  = !rx_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_W'(1);
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      p_state_d    = p_state_q;
      cmd_d        = cmd_q;
      dhi_d        = dhi_q;
      dlo_d        = dlo_q;
      to_cnt_d     = to_cnt_q;
      angle_d      = angle_q;
      bypass_d     = bypass_q;
      cfg_update_d = 1'b0;
      reply_req_d  = 1'b0;
      reply_byte_d = reply_byte_q;
      sum_c        = cmd_q + dhi_q + dlo_q;
      value_c      = {dhi_q, dlo_q};
      if (rx_ferr_q) begin
         p_state_d = P_IDLE;
         to_cnt_d  = '0;
      end else if (rx_valid_q) begin
         to_cnt_d = '0;
         case (p_state_q)
            P_IDLE: begin
               if (rx_shift_q == HDR_BYTE) begin
                  p_state_d = P_CMD;
               end
            end
            P_CMD: begin
               cmd_d     = rx_shift_q;
               p_state_d = P_DHI;
            end
            P_DHI: begin
               dhi_d     = rx_shift_q;
               p_state_d = P_DLO;
            end
            P_DLO: begin
               dlo_d     = rx_shift_q;
               p_state_d = P_SUM;
            end
            P_SUM: begin
               p_state_d    = P_IDLE;
               reply_req_d  = 1'b1;
               reply_byte_d = NAK_BYTE;
               if (sum_c == rx_shift_q) begin
                  if (cmd_q == 8'h01 && value_c <= 16'd359) begin
                     angle_d      = value_c[8:0];
                     cfg_update_d = 1'b1;
                     reply_byte_d = ACK_BYTE;
                  end else if (cmd_q == 8'h02) begin
                     bypass_d     = dlo_q[0];
                     cfg_update_d = 1'b1;
                     reply_byte_d = ACK_BYTE;
                  end
               end
            end
            default: p_state_d = P_IDLE;
         endcase
      end else if (p_state_q != P_IDLE) begin
         // A stalled sender must not leave the parser waiting mid-packet forever.
         if (to_cnt_q == TO_LAST) begin
            p_state_d = P_IDLE;
            to_cnt_d  = '0;
         end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
         end
      end else begin
         to_cnt_d = '0;
      end
   end

   // A request arriving while a byte is still going out is simply ignored.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      case (tx_state_q)
         T_IDLE: begin
            txd_d = 1'b1;
            if (reply_req_q) begin
               tx_state_d = T_BUSY;
               txd_d      = 1'b0;
               tx_shift_d = {1'b1, reply_byte_q};
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end
         end
         T_BUSY: begin
            if (tx_cnt_q == DIV_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tx_state_d = T_IDLE;
                  txd_d      = 1'b1;
               end else begin
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = {1'b1, tx_shift_q[8:1]};
                  tx_bit_d   = tx_bit_q + 4'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_W'(1);
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         rx_meta_q    <= 1'b0;
         rx_sync_q    <= 1'b0;
         rx_prev_q    <= 1'b0;
         rx_state_q   <= R_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         rx_valid_q   <= 1'b0;
         rx_ferr_q    <= 1'b0;
         p_state_q    <= P_IDLE;
         cmd_q        <= '0;
         dhi_q        <= '0;
         dlo_q        <= '0;
         to_cnt_q     <= '0;
         angle_q      <= 9'(ANGLE_INIT);
         bypass_q     <= 1'b0;
         cfg_update_q <= 1'b0;
         reply_req_q  <= 1'b0;
         reply_byte_q <= '0;
         tx_state_q   <= T_IDLE;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_shift_q   <= '1;
         txd_q        <= 1'b1;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_prev_q    <= rx_prev_d;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_valid_q   <= rx_valid_d;
         rx_ferr_q    <= rx_ferr_d;
         p_state_q    <= p_state_d;
         cmd_q        <= cmd_d;
         dhi_q        <= dhi_d;
         dlo_q        <= dlo_d;
         to_cnt_q     <= to_cnt_d;
         angle_q      <= angle_d;
         bypass_q     <= bypass_d;
         cfg_update_q <= cfg_update_d;
         reply_req_q  <= reply_req_d;
         reply_byte_q <= reply_byte_d;
         tx_state_q   <= tx_state_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_shift_q   <= tx_shift_d;
         txd_q        <= txd_d;
      end
   end

   assign O_uart_txd   = txd_q;
   assign O_angle      = angle_q;
   assign O_bypass     = bypass_q;
   assign O_cfg_update = cfg_update_q;

endmodule

// File: tb/tb_uart_rotate_cfg.sv
// Self-checking bench for uart_rotate_cfg: drives UART packets, decodes the reply line and
// compares against a packet-level model of the configuration registers.
module tb_uart_rotate_cfg;

   // 2_010_000 / 100_000 truncates to a 20-cycle bit, keeping the run short.
   localparam int CLK_FREQ   = 2_010_000;
   localparam int BAUD_RATE  = 100_000;
   localparam int DIV        = CLK_FREQ / BAUD_RATE;
   localparam int ANGLE_INIT = 180;

   logic       I_sys_clk = 1'b0;
   logic       I_rst_n;
   logic       I_uart_rxd;
   logic       O_uart_txd;
   logic [8:0] O_angle;
   logic       O_bypass;
   logic       O_cfg_update;

   int tests_run    = 0;
   int tests_failed = 0;

   int         cyc = 0;
   logic [7:0] tx_q[$];
   int         tx_starts = 0;
   int         last_tx_start = -1000;
   int         pulse_cnt = 0;
   int         last_pulse_cyc = -1000;

   int model_angle  = ANGLE_INIT;
   int model_bypass = 0;

   uart_rotate_cfg #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .ANGLE_INIT(ANGLE_INIT)
   ) dut (
      .I_sys_clk   (I_sys_clk),
      .I_rst_n     (I_rst_n),
      .I_uart_rxd  (I_uart_rxd),
      .O_uart_txd  (O_uart_txd),
      .O_angle     (O_angle),
      .O_bypass    (O_bypass),
      .O_cfg_update(O_cfg_update)
   );

   always #5 I_sys_clk = ~I_sys_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one 8N1 frame on the RX line with a chosen stop-bit level.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
      I_uart_rxd = 1'b0;
      repeat (DIV) @(negedge I_sys_clk);
      for (int i = 0; i < 8; i++) begin
         I_uart_rxd = b[i];
         repeat (DIV) @(negedge I_sys_clk);
      end
      I_uart_rxd = stop_bit;
      repeat (DIV) @(negedge I_sys_clk);
      I_uart_rxd = 1'b1;
   endtask

   task automatic modelPacket(input logic [7:0] cmd, input logic [7:0] dhi, input logic [7:0] dlo,
                              input logic [7:0] sum, output logic [7:0] reply, output bit accepted);
      int s;
      int v;
      s = (int'(cmd) + int'(dhi) + int'(dlo)) % 256;
      v = int'(dhi) * 256 + int'(dlo);
      accepted = 1'b0;
      reply    = 8'hEE;
      if (s == int'(sum)) begin
         if (cmd == 8'h01 && v <= 359) begin
            model_angle = v;
            accepted    = 1'b1;
            reply       = 8'hAA;
         end else if (cmd == 8'h02) begin
            model_bypass = int'(dlo[0]);
            accepted     = 1'b1;
            reply        = 8'hAA;
         end
      end
   endtask

   task automatic awaitReply(input string tag, input logic [7:0] exp_byte);
      int waited = 0;
      while (tx_q.size() == 0 && waited < 15 * DIV) begin
         @(negedge I_sys_clk);
         waited++;
      end
      checkOutput({tag, "_reply_seen"}, 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) checkOutput({tag, "_reply_byte"}, 32'(tx_q.pop_front()), 32'(exp_byte));
   endtask

   task automatic expectSilence(input string tag);
      repeat (15 * DIV) @(negedge I_sys_clk);
      checkOutput({tag, "_no_reply"}, 32'(tx_q.size()), 32'd0);
   endtask

   task automatic runPacket(input logic [7:0] cmd, input logic [7:0] dhi, input logic [7:0] dlo,
                            input logic [7:0] sum, input int gap_bits, input string tag);
      logic [7:0] exp_reply;
      bit         exp_acc;
      int         p0;
      modelPacket(cmd, dhi, dlo, sum, exp_reply, exp_acc);
      p0 = pulse_cnt;
      tx_q.delete();
      applyStimulus(8'h55, 1'b1);
      applyStimulus(cmd, 1'b1);
      repeat (gap_bits * DIV) @(negedge I_sys_clk);
      applyStimulus(dhi, 1'b1);
      applyStimulus(dlo, 1'b1);
      applyStimulus(sum, 1'b1);
      awaitReply(tag, exp_reply);
      checkOutput({tag, "_pulses"}, 32'(pulse_cnt - p0), exp_acc ? 32'd1 : 32'd0);
      checkOutput({tag, "_angle"}, 32'(O_angle), 32'(model_angle));
      checkOutput({tag, "_bypass"}, 32'(O_bypass), 32'(model_bypass));
      if (exp_acc) checkOutput({tag, "_tx_after_pulse"}, 32'(last_tx_start - last_pulse_cyc), 32'd1);
   endtask

   // Output monitor: decodes reply bytes, checks bit alignment and pulse/register coherence.
   initial begin : monitor
      logic       txd_prev = 1'b1;
      logic       cfg_prev = 1'b0;
      logic       rst_prev = 1'b0;
      logic [8:0] angle_prev = '0;
      logic       bypass_prev = 1'b0;
      logic       mon_busy = 1'b0;
      int         mon_start = 0;
      int         off;
      int         idx;
      logic [7:0] mon_byte = '0;
      forever begin
         @(negedge I_sys_clk);
         cyc++;
         if (!I_rst_n) begin
            mon_busy = 1'b0;
         end else begin
            if (O_cfg_update === 1'b1) begin
               checkOutput("cfg_single_cycle", 32'(cfg_prev), 32'd0);
               pulse_cnt++;
               last_pulse_cyc = cyc;
            end
            if (rst_prev && (O_angle !== angle_prev || O_bypass !== bypass_prev))
               checkOutput("change_has_pulse", 32'(O_cfg_update), 32'd1);
            if (!mon_busy) begin
               if (txd_prev === 1'b1 && O_uart_txd === 1'b0) begin
                  mon_busy      = 1'b1;
                  mon_start     = cyc;
                  tx_starts++;
                  last_tx_start = cyc;
               end
            end else begin
               off = cyc - mon_start;
               if (O_uart_txd !== txd_prev) checkOutput("tx_edge_align", 32'(off % DIV), 32'd0);
               if (off % DIV == DIV / 2) begin
                  idx = off / DIV;
                  if (idx == 0) begin
                     checkOutput("tx_start_bit", 32'(O_uart_txd), 32'd0);
                  end else if (idx <= 8) begin
                     mon_byte[idx-1] = O_uart_txd;
                  end else begin
                     checkOutput("tx_stop_bit", 32'(O_uart_txd), 32'd1);
                     tx_q.push_back(mon_byte);
                     mon_busy = 1'b0;
                  end
               end
            end
         end
         txd_prev    = O_uart_txd;
         cfg_prev    = O_cfg_update;
         rst_prev    = I_rst_n;
         angle_prev  = O_angle;
         bypass_prev = O_bypass;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      logic [7:0] cmd, dhi, dlo, sum;
      int         val;
      int         p0;
      int         s0;
      int         waited;

      I_rst_n    = 1'b0;
      I_uart_rxd = 1'b1;
      repeat (5) @(negedge I_sys_clk);
      checkOutput("rst_angle", 32'(O_angle), 32'(ANGLE_INIT));
      checkOutput("rst_bypass", 32'(O_bypass), 32'd0);
      checkOutput("rst_txd", 32'(O_uart_txd), 32'd1);
      checkOutput("rst_cfg_update", 32'(O_cfg_update), 32'd0);
      I_rst_n = 1'b1;
      repeat (3 * DIV) @(negedge I_sys_clk);
      checkOutput("idle_tx_starts", 32'(tx_starts), 32'd0);
      checkOutput("idle_pulses", 32'(pulse_cnt), 32'd0);
      checkOutput("idle_txd", 32'(O_uart_txd), 32'd1);

      runPacket(8'h01, 8'h01, 8'h68, 8'h6A, 0, "angle360_nak");
      runPacket(8'h02, 8'h00, 8'h01, 8'h03, 0, "bypass_on");
      runPacket(8'h01, 8'h00, 8'h5A, 8'h5B, 0, "angle90");
      runPacket(8'h01, 8'h00, 8'h5A, 8'h00, 0, "bad_sum");
      runPacket(8'h01, 8'h01, 8'h67, 8'h69, 0, "angle359");
      runPacket(8'h01, 8'h00, 8'h55, 8'h56, 0, "hdr_as_data");
      runPacket(8'h07, 8'h00, 8'h01, 8'h08, 0, "bad_cmd");
      runPacket(8'h02, 8'hFF, 8'h00, 8'h01, 0, "bypass_off_dhi");
      runPacket(8'h01, 8'h00, 8'h55, 8'h56, 0, "same_value");

      // Framing error on the CMD byte must drop the packet and resync the parser.
      tx_q.delete();
      p0 = pulse_cnt;
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h01, 1'b0);
      expectSilence("framing");
      checkOutput("framing_pulses", 32'(pulse_cnt - p0), 32'd0);
      runPacket(8'h01, 8'h00, 8'h2D, 8'h2E, 0, "after_framing");

      // A 50-bit stall abandons the packet; the tail bytes are then ignored.
      tx_q.delete();
      p0 = pulse_cnt;
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h01, 1'b1);
      repeat (50 * DIV) @(negedge I_sys_clk);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h5A, 1'b1);
      applyStimulus(8'h5B, 1'b1);
      expectSilence("timeout");
      checkOutput("timeout_pulses", 32'(pulse_cnt - p0), 32'd0);
      checkOutput("timeout_angle", 32'(O_angle), 32'(model_angle));

      runPacket(8'h01, 8'h00, 8'h5A, 8'h5B, 25, "short_gap");

      for (int i = 0; i < 10; i++) begin
         val = $urandom_range(0, 9);
         if (val < 5) cmd = 8'h01;
         else if (val < 8) cmd = 8'h02;
         else cmd = 8'($urandom_range(0, 255));
         if (cmd == 8'h01) begin
            val = $urandom_range(0, 400);
            dhi = 8'(val / 256);
            dlo = 8'(val % 256);
         end else begin
            dhi = 8'($urandom_range(0, 255));
            dlo = 8'($urandom_range(0, 255));
         end
         sum = 8'((int'(cmd) + int'(dhi) + int'(dlo)) % 256);
         if ($urandom_range(0, 4) == 0) sum = sum + 8'($urandom_range(1, 255));
         runPacket(cmd, dhi, dlo, sum, 0, "random");
      end

      // Reset in the middle of an ACK, while bit 0 (a zero) is on the line.
      tx_q.delete();
      s0 = tx_starts;
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h00, 1'b1);
      applyStimulus(8'h5A, 1'b1);
      applyStimulus(8'h5B, 1'b1);
      waited = 0;
      while (tx_starts == s0 && waited < 15 * DIV) begin
         @(negedge I_sys_clk);
         waited++;
      end
      checkOutput("midtx_started", 32'(tx_starts - s0), 32'd1);
      while ((cyc - last_tx_start) < DIV + DIV / 2) @(negedge I_sys_clk);
      checkOutput("midtx_txd_low", 32'(O_uart_txd), 32'd0);
      I_rst_n    = 1'b0;
      I_uart_rxd = 1'b0;
      #1;
      checkOutput("midtx_txd_released", 32'(O_uart_txd), 32'd1);
      checkOutput("midtx_angle", 32'(O_angle), 32'(ANGLE_INIT));
      checkOutput("midtx_bypass", 32'(O_bypass), 32'd0);
      model_angle  = ANGLE_INIT;
      model_bypass = 0;
      repeat (4) @(negedge I_sys_clk);

      // Release reset with the RX line held low: that must not count as a start bit.
      I_rst_n = 1'b1;
      repeat (DIV) @(negedge I_sys_clk);
      I_uart_rxd = 1'b1;
      repeat (2 * DIV) @(negedge I_sys_clk);
      checkOutput("after_reset_no_tx", 32'(O_uart_txd), 32'd1);
      runPacket(8'h01, 8'h00, 8'h5A, 8'h5B, 0, "low_line_release");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
